// File: rtl/pmod_da4_slave_pkg.sv
// Shared types and frame layout for the PMOD DA4 (AD5628) SPI responder.
package pmod_da4_pkg;

    typedef enum logic [3:0] {
        CMD_WR_IN      = 4'h0,
        CMD_UPD        = 4'h1,
        CMD_WR_UPD_ALL = 4'h2,
        CMD_WR_UPD     = 4'h3,
        CMD_RESET      = 4'h7,
        CMD_REF        = 4'h8
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DECODE,
        ST_HOLD
    } state_e;

    localparam logic [3:0] ADDR_ALL = 4'hF;

    // Bit positions within the 32-bit frame, bit 31 sent first.
    localparam int CMD_MSB  = 27;
    localparam int CMD_LSB  = 24;
    localparam int ADDR_MSB = 23;
    localparam int ADDR_LSB = 20;
    localparam int DATA_MSB = 19;
    localparam int DATA_LSB = 8;
    localparam int REF_BIT  = 0;

endpackage

// File: rtl/pmod_da4_slave_if.sv
// SPI pins between the DA4 master and this responder.
interface pmod_da4_slave_if;
    logic cs;
    logic sclk;
    logic mosi;

    modport master (output cs, output sclk, output mosi);
    modport slave  (input  cs, input  sclk, input  mosi);
endinterface

// File: rtl/pmod_da4_slave_sync_edge.sv
// Two-flop synchronizers for the SPI pins plus sclk-fall / cs-fall / cs-rise pulses.
module spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_i,
    input  logic sclk_i,
    input  logic mosi_i,
    output logic cs_o,
    output logic mosi_o,
    output logic sclk_fall_o,
    output logic cs_fall_o,
    output logic cs_rise_o
);
    localparam int STAGES = 2;

    logic [1:0]      cs_q, sclk_q, mosi_q;
    logic            cs_prev_q, sclk_prev_q;
    logic [STAGES:0] vld_pipe_q;
    logic            armed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_q        <= 2'b11;
            sclk_q      <= 2'b11;
            mosi_q      <= 2'b00;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b1;
            vld_pipe_q  <= '0;
        end else begin
            cs_q        <= {cs_q[0], cs_i};
            sclk_q      <= {sclk_q[0], sclk_i};
            mosi_q      <= {mosi_q[0], mosi_i};
            cs_prev_q   <= cs_q[1];
            sclk_prev_q <= sclk_q[1];
            vld_pipe_q  <= {vld_pipe_q[STAGES-1:0], 1'b1};
        end
    end

    // Edges only count once the whole chain holds real samples, so a cs
    // already low at reset release never looks like a fresh falling edge.
    assign armed = vld_pipe_q[STAGES];

    assign cs_o        = cs_q[1];
    assign mosi_o      = mosi_q[1];
    // Qualified on the previous cs sample: a last edge coinciding with cs rise still counts.
    assign sclk_fall_o = armed & sclk_prev_q & ~sclk_q[1] & ~cs_prev_q;
    assign cs_fall_o   = armed & cs_prev_q & ~cs_q[1];
    assign cs_rise_o   = armed & ~cs_prev_q & cs_q[1];

endmodule

// File: rtl/pmod_da4_slave.sv
// PMOD DA4 SPI responder: assembles 32-bit frames and applies AD5628 commands
// to the input/DAC register banks.
module pmod_da4_slave
    import pmod_da4_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int DATA_W  = 12,
    parameter int FRAME_W = 32
) (
    input  logic                      clk100mhz,
    input  logic                      rst_n,
    pmod_da4_slave_if.slave           spi,
    input  logic [$clog2(NUM_CH)-1:0] rd_addr,
    output logic [DATA_W-1:0]         rd_input,
    output logic [DATA_W-1:0]         rd_dac,
    output logic                      ref_on,
    output logic                      frame_valid,
    output logic [3:0]                frame_cmd,
    output logic [3:0]                frame_addr,
    output logic [DATA_W-1:0]         frame_data,
    output logic                      frame_err
);
    // Leading don't-care bits fall off the top of the shifter.
    localparam int                SH_W     = CMD_MSB + 1;
    localparam int                CNT_W    = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_W - 1);

    logic cs_lvl, mosi_s, sclk_fall, cs_fall, cs_rise;

    spi_sync_edge u_sync (
        .clk         (clk100mhz),
        .rst_n       (rst_n),
        .cs_i        (spi.cs),
        .sclk_i      (spi.sclk),
        .mosi_i      (spi.mosi),
        .cs_o        (cs_lvl),
        .mosi_o      (mosi_s),
        .sclk_fall_o (sclk_fall),
        .cs_fall_o   (cs_fall),
        .cs_rise_o   (cs_rise)
    );

    state_e                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [SH_W-1:0]                  sh_q, sh_d;
    logic                             do_decode, abort;

    always_ff @(posedge clk100mhz) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        do_decode = 1'b0;
        abort     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (sclk_fall && cnt_q == LAST_BIT) begin
                    sh_d    = {sh_q[SH_W-2:0], mosi_s};
                    state_d = ST_DECODE;
                end else if (cs_rise) begin
                    abort   = 1'b1;
                    sh_d    = '0;
                    state_d = ST_IDLE;
                end else if (sclk_fall) begin
                    sh_d  = {sh_q[SH_W-2:0], mosi_s};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DECODE: begin
                do_decode = 1'b1;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                if (cs_lvl) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic [3:0]                       cmd, addr;
    logic [DATA_W-1:0]                data;
    logic                             addr_ok, bad;
    logic [NUM_CH-1:0][DATA_W-1:0]    in_q, in_d, dac_q, dac_d;
    logic                             ref_q, ref_d;

    assign cmd     = sh_q[CMD_MSB:CMD_LSB];
    assign addr    = sh_q[ADDR_MSB:ADDR_LSB];
    assign data    = sh_q[DATA_LSB +: DATA_W];
    assign addr_ok = (addr == ADDR_ALL) || (32'(addr) < NUM_CH);

    always_comb begin
        in_d  = in_q;
        dac_d = dac_q;
        ref_d = ref_q;
        bad   = 1'b0;
        if (do_decode) begin
            case (cmd)
                CMD_WR_IN, CMD_UPD, CMD_WR_UPD_ALL, CMD_WR_UPD: begin
                    if (!addr_ok) begin
                        bad = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (addr == ADDR_ALL || addr == 4'(i)) begin
                                if (cmd != CMD_UPD)   in_d[i]  = data;
                                if (cmd == CMD_UPD)   dac_d[i] = in_q[i];
                                if (cmd == CMD_WR_UPD) dac_d[i] = data;
                            end
                        end
                        // Global update sees the value written by this same frame.
                        if (cmd == CMD_WR_UPD_ALL) dac_d = in_d;
                    end
                end
                CMD_RESET: begin
                    in_d  = '0;
                    dac_d = '0;
                    ref_d = 1'b0;
                end
                CMD_REF:  ref_d = sh_q[REF_BIT];
                default:  bad = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (!rst_n) begin
            in_q        <= '0;
            dac_q       <= '0;
            ref_q       <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_cmd   <= '0;
            frame_addr  <= '0;
            frame_data  <= '0;
        end else begin
            in_q        <= in_d;
            dac_q       <= dac_d;
            ref_q       <= ref_d;
            frame_valid <= do_decode;
            frame_err   <= bad | abort;
            if (do_decode) begin
                frame_cmd  <= cmd;
                frame_addr <= addr;
                frame_data <= data;
            end
        end
    end

    assign ref_on   = ref_q;
    assign rd_input = in_q[rd_addr];
    assign rd_dac   = dac_q[rd_addr];

endmodule

// File: tb/tb_pmod_da4_slave.sv
// Directed bench for pmod_da4_slave: frame-level register model checked every cycle.
module tb_pmod_da4_slave;

    logic clk100mhz = 1'b0;
    logic rst_n     = 1'b0;
    always #5 clk100mhz = ~clk100mhz;

    pmod_da4_slave_if spi();

    logic [2:0]  rd_addr;
    logic [11:0] rd_input, rd_dac, frame_data;
    logic        ref_on, frame_valid, frame_err;
    logic [3:0]  frame_cmd, frame_addr;

    pmod_da4_slave dut (
        .clk100mhz   (clk100mhz),
        .rst_n       (rst_n),
        .spi         (spi.slave),
        .rd_addr     (rd_addr),
        .rd_input    (rd_input),
        .rd_dac      (rd_dac),
        .ref_on      (ref_on),
        .frame_valid (frame_valid),
        .frame_cmd   (frame_cmd),
        .frame_addr  (frame_addr),
        .frame_data  (frame_data),
        .frame_err   (frame_err)
    );

    logic [11:0] m_in  [8];
    logic [11:0] m_dac [8];
    logic        m_ref;
    logic [3:0]  m_cmd, m_addr;
    logic [11:0] m_data;

    int          cyc    = 0;
    int          fv_due = -1;
    int          ab_due = -1;
    logic [31:0] fv_word;
    int          nvec   = 0;
    int          nerr   = 0;
    bit          chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int c = 0; c < 8; c++) begin
            m_in[c]  = 12'h000;
            m_dac[c] = 12'h000;
        end
        m_ref  = 1'b0;
        m_cmd  = 4'h0;
        m_addr = 4'h0;
        m_data = 12'h000;
    endfunction

    // Applies one complete frame; returns 1 when the frame is unsupported.
    function automatic bit model_apply(input logic [31:0] w);
        logic [3:0]  c, a;
        logic [11:0] d;
        c = w[27:24];
        a = w[23:20];
        d = w[19:8];
        m_cmd  = c;
        m_addr = a;
        m_data = d;
        if (c <= 4'h3) begin
            if (a >= 4'h8 && a != 4'hF) return 1'b1;
            for (int ch = 0; ch < 8; ch++) begin
                if (a == 4'hF || a == ch) begin
                    case (c)
                        4'h0: m_in[ch] = d;
                        4'h1: m_dac[ch] = m_in[ch];
                        4'h2: m_in[ch] = d;
                        default: begin m_in[ch] = d; m_dac[ch] = d; end
                    endcase
                end
            end
            if (c == 4'h2)
                for (int ch = 0; ch < 8; ch++) m_dac[ch] = m_in[ch];
            return 1'b0;
        end
        if (c == 4'h7) begin
            for (int ch = 0; ch < 8; ch++) begin
                m_in[ch]  = 12'h000;
                m_dac[ch] = 12'h000;
            end
            m_ref = 1'b0;
            return 1'b0;
        end
        if (c == 4'h8) begin
            m_ref = w[0];
            return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(negedge clk100mhz) begin
        bit ev, ef;
        ev = 1'b0;
        ef = 1'b0;
        cyc++;
        if (!rst_n) begin
            model_clear();
            fv_due = -1;
            ab_due = -1;
        end
        if (cyc == fv_due) begin
            ev = 1'b1;
            ef = model_apply(fv_word);
        end
        if (cyc == ab_due) ef = 1'b1;
        if (chk_en) begin
            chk("rd_input",    32'(rd_input),    32'(m_in[rd_addr]));
            chk("rd_dac",      32'(rd_dac),      32'(m_dac[rd_addr]));
            chk("ref_on",      32'(ref_on),      32'(m_ref));
            chk("frame_valid", 32'(frame_valid), 32'(ev));
            chk("frame_err",   32'(frame_err),   32'(ef));
            chk("frame_cmd",   32'(frame_cmd),   32'(m_cmd));
            chk("frame_addr",  32'(frame_addr),  32'(m_addr));
            chk("frame_data",  32'(frame_data),  32'(m_data));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk100mhz);
        #1;
    endtask

    // Sends nbits of w MSB first; rst_at >= 0 pulses rst_n before that bit.
    task automatic send(input logic [31:0] w, input int nbits, input int rst_at);
        spi.cs = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                tick(3);
                rst_n = 1'b1;
            end
            spi.mosi = w[31-i];
            tick(4);
            spi.sclk = 1'b0;
            if (i == 31 && rst_at < 0) begin
                fv_word = w;
                fv_due  = cyc + 4;
            end
            tick(4);
            spi.sclk = 1'b1;
        end
        tick(4);
        spi.cs = 1'b1;
        if (nbits < 32) ab_due = cyc + 3;
        tick(8);
    endtask

    task automatic sweep();
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            tick(1);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        spi.cs   = 1'b1;
        spi.sclk = 1'b1;
        spi.mosi = 1'b0;
        rd_addr  = 3'd0;
        rst_n    = 1'b0;
        tick(5);
        rst_n = 1'b1;
        tick(5);
        chk_en = 1'b1;
        chk("reset_ref_on", 32'(ref_on), 32'h0);
        chk("reset_rd_dac", 32'(rd_dac), 32'h0);
        chk("reset_frame_cmd", 32'(frame_cmd), 32'h0);

        send(32'h030AAA00, 32, -1);
        rd_addr = 3'd0;
        tick(1);
        chk("lit_wrupd_in0",  32'(rd_input),   32'hAAA);
        chk("lit_wrupd_dac0", 32'(rd_dac),     32'hAAA);
        chk("lit_frame_data", 32'(frame_data), 32'hAAA);
        chk("lit_frame_cmd",  32'(frame_cmd),  32'h3);
        sweep();

        send(32'h00312300, 32, -1);
        rd_addr = 3'd3;
        tick(1);
        chk("lit_wrin_in3",  32'(rd_input), 32'h123);
        chk("lit_wrin_dac3", 32'(rd_dac),   32'h000);
        send(32'h01300000, 32, -1);
        tick(1);
        chk("lit_upd_dac3", 32'(rd_dac), 32'h123);

        send(32'h02F55500, 32, -1);
        rd_addr = 3'd6;
        tick(1);
        chk("lit_all_in6",  32'(rd_input), 32'h555);
        chk("lit_all_dac6", 32'(rd_dac),   32'h555);
        sweep();

        send(32'h08000001, 32, -1);
        chk("lit_ref_on", 32'(ref_on), 32'h1);
        send(32'h07000000, 32, -1);
        rd_addr = 3'd6;
        tick(1);
        chk("lit_clr_ref",  32'(ref_on), 32'h0);
        chk("lit_clr_dac6", 32'(rd_dac), 32'h000);

        send(32'h03212300, 32, -1);
        send(32'h03276500, 20, -1);
        rd_addr = 3'd2;
        tick(1);
        chk("lit_abort_keep_in2", 32'(rd_input), 32'h123);
        send(32'h00476500, 32, -1);
        rd_addr = 3'd4;
        tick(1);
        chk("lit_after_abort_in4", 32'(rd_input), 32'h765);

        send(32'h0390FF00, 32, -1);
        send(32'h0B000000, 32, -1);
        chk("lit_bad_cmd", 32'(frame_cmd), 32'hB);
        rd_addr = 3'd2;
        tick(1);
        chk("lit_bad_keep_dac2", 32'(rd_dac), 32'h123);

        send(32'h03F12300, 32, 16);
        chk("lit_rst_ref",   32'(ref_on),     32'h0);
        chk("lit_rst_data",  32'(frame_data), 32'h000);
        chk("lit_rst_in2",   32'(rd_input),   32'h000);
        sweep();

        send(32'h03F12300, 32, -1);
        sweep();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pmod_da4_slave.md
# pmod_da4_slave

Behavioural-grade, synthesizable SPI responder modelling the PMOD DA4 (AD5628) on the receive side of our DAC link. It oversamples `cs`/`sclk`/`mosi` on the 100 MHz system clock and assembles 32-bit command frames. It decodes the frames into 8 input and 8 DAC registers and exposes the result through a frame strobe and a register read port. The block is the loop-back target for the PMOD DA4 SPI master in simulation and on-board self-test.

## Interface
- `NUM_CH`, 8: number of DAC channels.
- `DATA_W`, 12: DAC code width.
- `FRAME_W`, 32: bits per SPI frame.

- `clk100mhz` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `cs` in 1: SYNC from master, active low, asynchronous to `clk100mhz`.
- `sclk` in 1: SPI clock from master, asynchronous.
- `mosi` in 1: serial data from master, MSB first.
- `rd_addr` in 3: channel selected for readback.
- `rd_input` out 12: input register of `rd_addr`.
- `rd_dac` out 12: DAC register of `rd_addr`.
- `ref_on` out 1: internal reference enable.
- `frame_valid` out 1: one-cycle pulse when a complete frame is decoded.
- `frame_cmd` out 4: command field of the last frame.
- `frame_addr` out 4: address field of the last frame.
- `frame_data` out 12: data field of the last frame.
- `frame_err` out 1: one-cycle pulse on an aborted frame or unsupported command/address.

## Operation
- Inputs pass through a 2-flop synchronizer. The edge detector flags the synchronized `sclk` falling edge while synchronized `cs` = 0. `sclk` high and low phases must each be ≥ 2 `clk100mhz` periods.
- Frame layout, bit 31 first: [31:28] don't care, [27:24] cmd, [23:20] addr, [19:8] data, [7:1] don't care, [0] ref bit.
- FSM states:
  - IDLE to SHIFT on synchronized `cs` falling; bit counter cleared.
  - SHIFT: shift `mosi` in on each qualifying edge. On the 32nd edge, go to DECODE.
  - DECODE: lasts 1 cycle. Apply command, pulse `frame_valid`, go to HOLD.
  - HOLD: ignore further edges until `cs` rises, then go to IDLE.
  - A `cs` rise in SHIFT with fewer than 32 bits: discard the shifter, pulse `frame_err`, no register change, go to IDLE.
- Commands:
  - 0x0: write input[addr].
  - 0x1: dac[addr] ← input[addr].
  - 0x2: write input[addr], then all dac ← input. The update uses the newly written value.
  - 0x3: write input[addr] and dac[addr].
  - 0x7: all input/dac ← 0 and `ref_on` ← 0.
  - 0x8: `ref_on` ← bit 0.
  - Any other cmd: `frame_valid` and `frame_err` both pulse; no state change.
- Addressing for cmds 0x0–0x3: addr 0–7 selects one channel. addr 0xF selects all channels. addr 8–14 acts like an unsupported cmd.
- `frame_cmd`/`frame_addr`/`frame_data` update in DECODE and hold until the next DECODE.
- Reset values: all registers 0, `ref_on` 0, `frame_*` 0, strobes 0, FSM IDLE, synchronizer flops 1 for `cs`/`sclk` and 0 for `mosi`.
- Reset asserted mid-frame: the frame is lost. After release, wait for a fresh `cs` falling edge; a `cs` already low is not treated as a new frame.

## Timing
- From the external 32nd `sclk` fall to `frame_valid`: 4 cycles (2 sync, 1 edge detect/shift, 1 DECODE).
- Register updates, `rd_*` changes and `frame_valid` all become visible in the same cycle, the one after DECODE.
- `rd_input`/`rd_dac` are combinational from `rd_addr` and the registers, with 0 added latency.
- `frame_err` for an abort fires 3 cycles after the external `cs` rise.
- `cs` rising and the 32nd edge in the same synchronized cycle: the edge wins. The frame decodes, then the FSM passes through HOLD to IDLE.

## Structure
- Package `pmod_da4_pkg`: cmd enum (`CMD_WR_IN`, `CMD_UPD`, `CMD_WR_UPD_ALL`, `CMD_WR_UPD`, `CMD_RESET`, `CMD_REF`), FSM state enum, `ADDR_ALL` = 4'hF, field bit-position constants.
- Sub-module `spi_sync_edge`: synchronizers plus `sclk` fall / `cs` fall / `cs` rise pulses.

## Test plan
- Frame 32'h030AAA00 (cmd 3, ch 0, data 0xAAA) → `frame_valid` once; `rd_dac`[0] = `rd_input`[0] = 0xAAA; `frame_err` 0.
- Frame 32'h00312300 then 32'h01300000 → after the first frame, input[3] = 0x123 and dac[3] = 0. After the second, dac[3] = 0x123.
- Frame 32'h02F55500 → every input and dac = 0x555.
- Frame 32'h08000001, then 32'h07000000 → `ref_on` goes 1, then all registers and `ref_on` return to 0.
- Abort: `cs` rises after 20 edges → `frame_err` pulse, no `frame_valid`, registers unchanged. A following good frame decodes normally.
- Frame 32'h0390FF00 (addr 9) and 32'h0B000000 (cmd 0xB) → `frame_valid` and `frame_err` both pulse; no register change. Then `rst_n` = 0 mid-frame → all outputs read 0.
